// File: rtl/wb_ext_arbiter_pkg.sv
// wb_ext_arbiter_pkg: Wishbone widths, CTI encodings and arbiter state type
// shared by the external-port arbiter files.
package wb_ext_arbiter_pkg;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int CTI_W = 3;
    localparam int BTE_W = 2;

    localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
    localparam logic [CTI_W-1:0] CTI_END     = 3'b111;

    typedef enum logic {ST_IDLE, ST_OWNED} state_e;

    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        oh2idx = '0;
        for (int i = 0; i < 16; i++) oh2idx = oh[i] ? 4'(i) : oh2idx;
    endfunction
endpackage

// File: rtl/wb_ext_arbiter_arb_rr.sv
// arb_rr: combinational round-robin pick, searching upward from the master
// after last_i with wrap-around and skipping masters in excl_i.
module arb_rr
    import wb_ext_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] last_i,
    input  logic [N-1:0] excl_i,
    output logic [N-1:0] gnt_o
);
    logic [N-1:0] req;
    logic [N-1:0] rot;
    int           base;
    int           pos;

    // Rotate so bit 0 is the master right after last, take the lowest set bit, rotate back.
    always_comb begin
        req   = req_i & ~excl_i;
        base  = int'(oh2idx(16'(last_i))) + 1;
        rot   = N'({req, req} >> base);
        pos   = -1;
        for (int i = N - 1; i >= 0; i--) pos = rot[i] ? i : pos;
        gnt_o = (pos < 0) ? '0 : N'(1) << ((pos + base) % N);
    end
endmodule

// File: rtl/wb_ext_arbiter.sv
// wb_ext_arbiter: shares one external Wishbone slave among NODES masters,
// round-robin, ownership held for the whole cyc period, with a slave watchdog.
module wb_ext_arbiter
    import wb_ext_arbiter_pkg::*;
#(
    parameter int NODES   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NODES*ADR_W-1:0] m_adr_i,
    input  logic [NODES*DAT_W-1:0] m_dat_i,
    input  logic [NODES*SEL_W-1:0] m_sel_i,
    input  logic [NODES-1:0]       m_cyc_i,
    input  logic [NODES-1:0]       m_stb_i,
    input  logic [NODES-1:0]       m_we_i,
    input  logic [NODES-1:0]       m_cab_i,
    input  logic [NODES*CTI_W-1:0] m_cti_i,
    input  logic [NODES*BTE_W-1:0] m_bte_i,
    output logic [NODES-1:0]       m_ack_o,
    output logic [NODES-1:0]       m_err_o,
    output logic [NODES-1:0]       m_rty_o,
    output logic [DAT_W-1:0]       m_dat_o,
    output logic [ADR_W-1:0]       s_adr_o,
    output logic [DAT_W-1:0]       s_dat_o,
    output logic [SEL_W-1:0]       s_sel_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic                   s_cab_o,
    output logic [CTI_W-1:0]       s_cti_o,
    output logic [BTE_W-1:0]       s_bte_o,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    input  logic                   s_rty_i,
    input  logic [DAT_W-1:0]       s_dat_i,
    output logic [NODES-1:0]       grant_o,
    output logic                   timeout_o
);
    localparam int IW    = NODES > 1 ? $clog2(NODES) : 1;
    localparam int WW    = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_M1 = TIMEOUT > 0 ? TIMEOUT - 1 : 0;

    state_e           state_d, state_q;
    logic [NODES-1:0] grant_d, grant_q;
    logic [IW-1:0]    last_d, last_q;
    logic [WW-1:0]    wdog_d, wdog_q;
    logic             timeout_d, timeout_q;
    logic [NODES-1:0] pick, excl;
    logic             owner_cyc, cyc_raw, stb_raw, resp, fire;

    // While owned, the releasing master is excluded so its re-request waits a cycle.
    assign excl      = (state_q == ST_OWNED) ? grant_q : '0;
    assign owner_cyc = |(grant_q & m_cyc_i);

    arb_rr #(.N(NODES)) u_arb (
        .req_i  (m_cyc_i),
        .last_i (NODES'(1) << last_q),
        .excl_i (excl),
        .gnt_o  (pick)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == ST_IDLE || !owner_cyc) begin
            state_d = (|pick) ? ST_OWNED : ST_IDLE;
            grant_d = pick;
            last_d  = (|pick) ? IW'(oh2idx(16'(pick))) : last_q;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        cyc_raw = 1'b0;
        stb_raw = 1'b0;
        s_we_o  = 1'b0;
        s_cab_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int i = 0; i < NODES; i++) begin
            if (grant_q[i]) begin
                s_adr_o = m_adr_i[i*ADR_W +: ADR_W];
                s_dat_o = m_dat_i[i*DAT_W +: DAT_W];
                s_sel_o = m_sel_i[i*SEL_W +: SEL_W];
                cyc_raw = m_cyc_i[i];
                stb_raw = m_stb_i[i];
                s_we_o  = m_we_i[i];
                s_cab_o = m_cab_i[i];
                s_cti_o = m_cti_i[i*CTI_W +: CTI_W];
                s_bte_o = m_bte_i[i*BTE_W +: BTE_W];
            end
        end
    end

    assign resp      = s_ack_i | s_err_i | s_rty_i;
    assign fire      = (TIMEOUT > 0) && stb_raw && !resp && (wdog_q == WW'(TO_M1));
    assign wdog_d    = ((TIMEOUT > 0) && stb_raw && !resp && !fire && grant_d == grant_q) ? wdog_q + WW'(1) : '0;
    assign timeout_d = timeout_q | fire;

    assign s_cyc_o   = cyc_raw & ~fire;
    assign s_stb_o   = stb_raw & ~fire;
    assign m_ack_o   = grant_q & {NODES{stb_raw & s_ack_i}};
    assign m_err_o   = grant_q & {NODES{(stb_raw & s_err_i) | fire}};
    assign m_rty_o   = grant_q & {NODES{stb_raw & s_rty_i}};
    assign m_dat_o   = (|grant_q) ? s_dat_i : '0;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NODES - 1);
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_wb_ext_arbiter.sv
// tb_wb_ext_arbiter: scenario tasks with scripted masters, a one-wait-state
// slave and an ack scoreboard for wb_ext_arbiter (NODES=4, TIMEOUT=8).
module tb_wb_ext_arbiter;
    import wb_ext_arbiter_pkg::*;
    localparam int NODES   = 4;
    localparam int TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NODES*32-1:0]  m_adr_i, m_dat_i;
    logic [NODES*4-1:0]   m_sel_i;
    logic [NODES-1:0]     m_cyc_i, m_stb_i, m_we_i, m_cab_i;
    logic [NODES*3-1:0]   m_cti_i;
    logic [NODES*2-1:0]   m_bte_i;
    logic [NODES-1:0]     m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [31:0]          m_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]           s_sel_o;
    logic                 s_cyc_o, s_stb_o, s_we_o, s_cab_o, timeout_o;
    logic [2:0]           s_cti_o;
    logic [1:0]           s_bte_o;
    logic                 s_ack_i, s_err_i, s_rty_i;

    wb_ext_arbiter #(.NODES(NODES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_cab_i(m_cab_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] adr);
        return (adr == 32'h100) ? 32'hDEADBEEF : adr ^ 32'h5A5A_0000;
    endfunction

    // Slave answers every strobe one cycle after it is first seen.
    logic pend;
    bit   slave_on = 1'b1;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pend <= 1'b0;
        else        pend <= slave_on && s_stb_o && !s_ack_i;
    assign s_ack_i = slave_on && pend;
    assign s_err_i = 1'b0;
    assign s_rty_i = 1'b0;
    assign s_dat_i = mem_rd(s_adr_o);

    typedef struct {int idx; logic [31:0] adr;} exp_t;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          nb[NODES];
    logic [31:0] madr[NODES];
    bit          bur[NODES];

    function automatic bit busy();
        busy = 1'b0;
        for (int i = 0; i < NODES; i++) if (nb[i] > 0) busy = 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NODES; i++) begin
            m_cyc_i[i]         = nb[i] > 0;
            m_stb_i[i]         = nb[i] > 0;
            m_we_i[i]          = 1'b0;
            m_cab_i[i]         = bur[i] && nb[i] > 0;
            m_adr_i[i*32 +: 32] = madr[i];
            m_dat_i[i*32 +: 32] = madr[i] ^ 32'(i);
            m_sel_i[i*4 +: 4]   = 4'hF;
            m_cti_i[i*3 +: 3]   = !bur[i] ? CTI_CLASSIC : (nb[i] == 1 ? CTI_END : CTI_INCR);
            m_bte_i[i*2 +: 2]   = 2'b00;
        end
    endtask

    task automatic clear_masters();
        for (int i = 0; i < NODES; i++) begin
            nb[i] = 0;
            madr[i] = '0;
            bur[i] = 1'b0;
        end
    endtask

    task automatic start(input int i, input int beats, input logic [31:0] adr, input bit burst);
        exp_t e;
        nb[i] = beats;
        madr[i] = adr;
        bur[i] = burst;
        for (int b = 0; b < beats; b++) begin
            e.idx = i;
            e.adr = adr + 32'(b * 4);
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (m_ack_o != '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack ack=%b dat=%h", m_ack_o, m_dat_o);
            end else begin
                e = sb.pop_front();
                if (m_ack_o !== 4'(1 << e.idx) || m_dat_o !== mem_rd(e.adr)) begin
                    errors++;
                    $display("FAIL sb_ack ack=%b dat=%h expected ack=%b dat=%h",
                             m_ack_o, m_dat_o, 4'(1 << e.idx), mem_rd(e.adr));
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        for (int i = 0; i < NODES; i++)
            if (nb[i] > 0 && (m_ack_o[i] || m_err_o[i])) begin
                nb[i]--;
                madr[i] += 32'd4;
            end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int limit);
        int n = 0;
        while (busy() && n < limit) begin
            sample();
            advance();
            n++;
        end
        checks++;
        if (busy() || sb.size() != 0) begin
            errors++;
            $display("FAIL run_done cycles=%0d sb_left=%0d expected idle with empty scoreboard", n, sb.size());
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cab_o, s_cti_o, s_bte_o,
             m_ack_o, m_err_o, m_rty_o, m_dat_o, timeout_o} !== '0) begin
            errors++;
            $display("FAIL %s grant=%b s_cyc=%b s_stb=%b s_adr=%h ack=%b err=%b dat=%h timeout=%b expected all 0",
                     name, grant_o, s_cyc_o, s_stb_o, s_adr_o, m_ack_o, m_err_o, m_dat_o, timeout_o);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        clear_masters();
        drive();
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_masters();
        drive();
        #23 check_zero("reset_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        sample();
        check_zero("reset_release");
        advance();
    endtask

    task automatic test_single();
        start(2, 1, 32'h100, 1'b0);
        advance();
        sample();
        checks++;
        if (grant_o !== 4'b0000 || s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL single_latency grant=%b s_stb=%b expected 0000/0", grant_o, s_stb_o);
        end
        advance();
        sample();
        checks++;
        if (grant_o !== 4'b0100 || s_stb_o !== 1'b1 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h100 ||
            s_dat_o !== 32'h102 || s_sel_o !== 4'hF || s_cti_o !== CTI_CLASSIC || m_ack_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_grant grant=%b stb=%b adr=%h dat=%h cti=%b ack=%b expected 0100/1/100/102/000/0000",
                     grant_o, s_stb_o, s_adr_o, s_dat_o, s_cti_o, m_ack_o);
        end
        advance();
        sample();
        checks++;
        if (m_ack_o !== 4'b0100 || m_dat_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_ack ack=%b dat=%h expected 0100/deadbeef", m_ack_o, m_dat_o);
        end
        advance();
        sample();
        checks++;
        if (m_ack_o !== 4'b0000 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_pulse ack=%b s_cyc=%b expected 0000/0", m_ack_o, s_cyc_o);
        end
        advance();
        sample();
        checks++;
        if (grant_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_release grant=%b expected 0000", grant_o);
        end
        advance();
    endtask

    task automatic test_all_four();
        logic [NODES-1:0] order[$];
        logic [NODES-1:0] prev = '0;
        bit               seen = 1'b0;
        bit               ok;
        int               dead = 0;
        int               n = 0;
        do_reset();
        for (int i = 0; i < NODES; i++) start(i, 1, 32'h200 + 32'(i * 16), 1'b0);
        advance();
        while (busy() && n < 60) begin
            sample();
            if (grant_o != '0) begin
                if (grant_o != prev) order.push_back(grant_o);
                seen = 1'b1;
            end else if (seen) dead++;
            prev = grant_o;
            advance();
            n++;
        end
        checks++;
        if (dead != 0) begin
            errors++;
            $display("FAIL all_four_dead dead_cycles=%0d expected 0", dead);
        end
        checks++;
        ok = order.size() == 4;
        for (int k = 0; k < 4; k++) if (ok && order[k] !== 4'(1 << k)) ok = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL all_four_order grants_seen=%0d first=%b expected 0001,0010,0100,1000",
                     order.size(), order.size() > 0 ? order[0] : 4'b0000);
        end
        run(10);
    endtask

    task automatic test_burst();
        int n = 0;
        start(1, 4, 32'h300, 1'b1);
        advance();
        sample();
        advance();
        start(0, 1, 32'h400, 1'b0);
        while (nb[1] > 0 && n < 60) begin
            sample();
            checks++;
            if (grant_o !== 4'b0010 || s_cti_o !== (nb[1] == 1 ? CTI_END : CTI_INCR)) begin
                errors++;
                $display("FAIL burst_own grant=%b cti=%b beats_left=%0d expected 0010", grant_o, s_cti_o, nb[1]);
            end
            advance();
            n++;
        end
        run(20);
    endtask

    task automatic test_reraise();
        int n = 0;
        do_reset();
        start(0, 1, 32'h700, 1'b0);
        start(3, 1, 32'h710, 1'b0);
        advance();
        while (nb[0] > 0 && n < 20) begin
            sample();
            advance();
            n++;
        end
        start(0, 1, 32'h720, 1'b0);
        sample();
        advance();
        sample();
        checks++;
        if (grant_o !== 4'b1000) begin
            errors++;
            $display("FAIL reraise_next grant=%b expected 1000", grant_o);
        end
        advance();
        run(30);
    endtask

    task automatic test_timeout();
        int n = 0;
        int g = 0;
        slave_on = 1'b0;
        nb[2] = 1;
        madr[2] = 32'h800;
        bur[2] = 1'b0;
        advance();
        while (nb[2] > 0 && g < 40) begin
            sample();
            if (grant_o == 4'b0100) begin
                n++;
                checks++;
                if (n < TIMEOUT ? (m_err_o !== 4'b0000 || s_stb_o !== 1'b1)
                                : (m_err_o !== 4'b0100 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0)) begin
                    errors++;
                    $display("FAIL wdog_cycle n=%0d err=%b s_stb=%b s_cyc=%b", n, m_err_o, s_stb_o, s_cyc_o);
                end
            end
            advance();
            g++;
        end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL wdog_len stb_cycles=%0d expected %0d", n, TIMEOUT);
        end
        repeat (3) begin
            sample();
            checks++;
            if (timeout_o !== 1'b1 || m_err_o !== 4'b0000) begin
                errors++;
                $display("FAIL wdog_sticky timeout=%b err=%b expected 1/0000", timeout_o, m_err_o);
            end
            advance();
        end
        do_reset();
        slave_on = 1'b1;
    endtask

    task automatic test_reset_burst();
        start(1, 4, 32'h900, 1'b1);
        advance();
        repeat (4) begin
            sample();
            advance();
        end
        do_reset();
        start(0, 1, 32'hA00, 1'b0);
        start(1, 1, 32'hA10, 1'b0);
        start(3, 1, 32'hA30, 1'b0);
        advance();
        sample();
        advance();
        sample();
        checks++;
        if (grant_o !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_priority grant=%b expected 0001", grant_o);
        end
        advance();
        run(40);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_burst();
        test_reraise();
        test_timeout();
        test_reset_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_ext_arbiter.md
# wb_ext_arbiter

Shares one external Wishbone slave, such as the board memory controller, among the NODES per-tile `wb_ext_*` master ports of a compute-tile system. Masters are granted round-robin. A master keeps ownership for its entire `cyc` period, which covers single accesses and `cti`/`bte` bursts. A watchdog terminates transfers the slave never answers. The block sits between the system top level and the external memory interface.

## Interface

Parameters:
- `NODES`, default 4: number of masters, range 1..16.
- `TIMEOUT`, default 1023: cycles `stb` may wait for `ack`/`err`/`rty` before the arbiter aborts. 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_adr_i` in NODES*32: master addresses, master i in bits [i*32+:32].
- `m_dat_i` in NODES*32: master write data.
- `m_sel_i` in NODES*4: byte selects.
- `m_cyc_i`, `m_stb_i`, `m_we_i`, `m_cab_i` in NODES: per-master strobes.
- `m_cti_i` in NODES*3, `m_bte_i` in NODES*2: burst tags.
- `m_ack_o`, `m_err_o`, `m_rty_o` out NODES: per-master responses.
- `m_dat_o` out 32: shared read data, the same value to all masters.
- `s_adr_o` out 32, `s_dat_o` out 32, `s_sel_o` out 4, `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_cab_o` out 1, `s_cti_o` out 3, `s_bte_o` out 2: slave side.
- `s_ack_i`, `s_err_i`, `s_rty_i` in 1, `s_dat_i` in 32: slave responses.
- `grant_o` out NODES: one-hot current owner, 0 when idle.
- `timeout_o` out 1: sticky watchdog flag.

## Operation

- State machine has two states, IDLE and OWNED. Registers: `grant` (one-hot), `last` (index of the last owner), `wdog` counter, `timeout` flag.
- IDLE: if any `m_cyc_i` is high, pick the first requester searching upward from `last+1` with wrap-around. Load `grant`, set `last`, go to OWNED.
- OWNED: `s_*` outputs are a combinational mux of the granted master's signals.
  - `s_ack_i`/`s_err_i`/`s_rty_i` go only to the granted master. All other masters see 0.
  - `m_dat_o` = `s_dat_i`.
- Release: in OWNED, when the granted master's `cyc` is low, hand off in the same cycle.
  - If other requesters are present, the round-robin pick excludes the releasing master and the next `grant` is loaded at the next edge.
  - Otherwise go to IDLE and clear `grant`.
  - The releasing master's own re-request is considered only after it has been out of ownership for one cycle.
- Requests never pre-empt an owner. Bursts, with `cti`=010 and any `bte`, stay atomic because ownership follows `cyc`.
- Watchdog (TIMEOUT>0):
  - `wdog` increments each OWNED cycle in which `s_stb_o` is high and no response arrives.
  - `wdog` clears on any response, on `stb` low, or on a grant change.
  - When `wdog` reaches TIMEOUT, in that same cycle: drive `m_err_o` to the owner, force `s_cyc_o`/`s_stb_o` to 0, set `timeout` (cleared only by reset), and clear `wdog`.
- A slave response arriving while `s_stb_o` is low is ignored.
- When `grant` is 0, all `s_*` outputs are 0.

## Timing

- Reset values: `grant`=0, `last`=NODES-1 (so master 0 wins first), `wdog`=0, `timeout`=0, state IDLE, all `s_*` and `m_*_o` outputs 0.
- Arbitration latency: a request seen at edge k is granted and driven on `s_*` after edge k+1, so the first `s_stb_o` appears 1 cycle after `m_cyc_i` rises from IDLE.
- Handoff: zero dead cycles. The owner drops `cyc` in cycle k and the new owner drives `s_*` in cycle k+1.
- The response path is purely combinational, so there is no added ack latency. The slave must tolerate the `cyc` mux changing only at grant changes.
- If reset is asserted mid-transfer, all outputs go to 0 immediately. The in-flight transfer is lost and masters must restart.
- With NODES=1 the master is granted after 1 cycle and the block otherwise passes signals straight through.

## Structure

- The Wishbone width constants (ADR=32, DAT=32, SEL=4, CTI=3, BTE=2) belong in the shared `optimsoc` package, alongside the CTI encodings (CLASSIC=000, INCR=010, END=111).
- One sub-module, `arb_rr`: parameterized round-robin arbiter. Inputs are the request vector, `last` one-hot and an exclude mask; output is the one-hot next grant. It is purely combinational.
- Top level: FSM, mux, response demux and watchdog.

## Test plan

- Single master, NODES=4: master 2 does a classic read at 0x100 and the slave acks 1 cycle later with 0xDEADBEEF. Required: `grant_o`=0100, `m_ack_o`=0100 for exactly 1 cycle, `m_dat_o`=0xDEADBEEF.
- All 4 masters assert `cyc` at once after reset, each doing one access. Required: grants follow the order 0,1,2,3 with zero dead cycles between owners.
- Master 1 runs a 4-beat INCR burst (`cti` 010,010,010,111) while master 0 requests. Required: master 0 is not granted until master 1 drops `cyc`, and all 4 acks go to master 1 only.
- Master 0 drops `cyc` and re-raises it at once while master 3 is waiting. Required: master 3 is granted next, and master 0 only after master 3 releases.
- TIMEOUT=8 with the slave never answering master 2. Required: `m_err_o[2]` pulses on the 8th `stb` cycle, `s_stb_o`=0 in that cycle, and `timeout_o` stays 1 until `rst_n` is asserted low.
- Assert `rst_n` low during a burst. Required: all outputs 0 asynchronously, and after release master 0 has priority again.
